// File: rtl/cl_mem_axi_pkg.sv
// Shared types and constants for the single-outstanding memory AXI initiator.
package cl_mem_axi_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_REQ  = 3'd1,
    WR_RESP = 3'd2,
    RD_ADDR = 3'd3,
    RD_DATA = 3'd4,
    RSP     = 3'd5
  } mem_axi_mst_state_e;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

  localparam int MEM_AXI_WDOG_W = 16;

  // The bus is 64 bits wide, so every beat address is forced onto an 8-byte boundary.
  function automatic logic [63:0] align8(input logic [63:0] addr);
    return addr & ~64'h7;
  endfunction

endpackage

// File: rtl/cl_mem_axi_wdog.sv
// Per-transaction cycle watchdog: clearable saturating counter plus a sticky
// timeout flag that only reset can clear.
module cl_mem_axi_wdog
  import cl_mem_axi_pkg::*;
#(
  parameter int TIMEOUT = 1024
) (
  input  logic clk,
  input  logic rstn,
  input  logic clr,
  input  logic en,
  output logic err_timeout
);

  localparam logic [MEM_AXI_WDOG_W-1:0] LIMIT = MEM_AXI_WDOG_W'(TIMEOUT);

  logic [MEM_AXI_WDOG_W-1:0] cnt;

  // A TIMEOUT of 0 disables the flag; the counter still runs but is never compared.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt         <= '0;
      err_timeout <= 1'b0;
    end else begin
      if (clr) begin
        cnt <= '0;
      end else if (en && (cnt != '1)) begin
        cnt <= cnt + 1'b1;
      end
      if ((TIMEOUT != 0) && (cnt == LIMIT)) begin
        err_timeout <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/cl_mem_axi_master.sv
// Command-driven initiator: turns one valid/ready command into a single-beat
// AXI write (AW+W, then B) or read (AR, then R) and returns a response.
module cl_mem_axi_master
  import cl_mem_axi_pkg::*;
#(
  parameter int TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        rstn,

  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [63:0] cmd_addr,
  input  logic [63:0] cmd_wdata,
  input  logic [7:0]  cmd_wstrb,

  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_write,
  output logic [63:0] rsp_rdata,
  output logic [1:0]  rsp_resp,

  output logic        mem_axi_awvalid,
  input  logic        mem_axi_awready,
  output logic [63:0] mem_axi_awaddr,
  output logic        mem_axi_wvalid,
  input  logic        mem_axi_wready,
  output logic [63:0] mem_axi_wdata,
  output logic [7:0]  mem_axi_wstrb,
  input  logic        mem_axi_bvalid,
  output logic        mem_axi_bready,
  input  logic [1:0]  mem_axi_bresp,
  output logic        mem_axi_arvalid,
  input  logic        mem_axi_arready,
  output logic [63:0] mem_axi_araddr,
  input  logic        mem_axi_rvalid,
  output logic        mem_axi_rready,
  input  logic [1:0]  mem_axi_rresp,
  input  logic [63:0] mem_axi_rdata,

  output logic [31:0] wr_count,
  output logic [31:0] rd_count,
  output logic        err_timeout
);

  mem_axi_mst_state_e state;

  logic cmd_fire;
  logic aw_done;
  logic w_done;
  logic wdog_en;

  assign cmd_ready = (state == IDLE);
  assign cmd_fire  = cmd_valid && cmd_ready;

  // A channel counts as done if its valid already dropped or it handshakes this cycle.
  assign aw_done = !mem_axi_awvalid || mem_axi_awready;
  assign w_done  = !mem_axi_wvalid  || mem_axi_wready;

  assign wdog_en = (state == WR_REQ) || (state == WR_RESP) ||
                   (state == RD_ADDR) || (state == RD_DATA);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state           <= IDLE;
      mem_axi_awvalid <= 1'b0;
      mem_axi_awaddr  <= '0;
      mem_axi_wvalid  <= 1'b0;
      mem_axi_wdata   <= '0;
      mem_axi_wstrb   <= '0;
      mem_axi_bready  <= 1'b0;
      mem_axi_arvalid <= 1'b0;
      mem_axi_araddr  <= '0;
      mem_axi_rready  <= 1'b0;
      rsp_valid       <= 1'b0;
      rsp_write       <= 1'b0;
      rsp_rdata       <= '0;
      rsp_resp        <= '0;
      wr_count        <= '0;
      rd_count        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_fire) begin
            mem_axi_awaddr <= align8(cmd_addr);
            mem_axi_araddr <= align8(cmd_addr);
            mem_axi_wdata  <= cmd_wdata;
            mem_axi_wstrb  <= cmd_wstrb;
            if (cmd_write) begin
              mem_axi_awvalid <= 1'b1;
              mem_axi_wvalid  <= 1'b1;
              state           <= WR_REQ;
            end else begin
              mem_axi_arvalid <= 1'b1;
              state           <= RD_ADDR;
            end
          end
        end

        WR_REQ: begin
          if (mem_axi_awready) begin
            mem_axi_awvalid <= 1'b0;
          end
          if (mem_axi_wready) begin
            mem_axi_wvalid <= 1'b0;
          end
          if (aw_done && w_done) begin
            mem_axi_bready <= 1'b1;
            state          <= WR_RESP;
          end
        end

        WR_RESP: begin
          if (mem_axi_bvalid) begin
            mem_axi_bready <= 1'b0;
            rsp_valid      <= 1'b1;
            rsp_write      <= 1'b1;
            rsp_rdata      <= '0;
            rsp_resp       <= mem_axi_bresp;
            wr_count       <= wr_count + 32'd1;
            state          <= RSP;
          end
        end

        RD_ADDR: begin
          if (mem_axi_arready) begin
            mem_axi_arvalid <= 1'b0;
            mem_axi_rready  <= 1'b1;
            state           <= RD_DATA;
          end
        end

        RD_DATA: begin
          if (mem_axi_rvalid) begin
            mem_axi_rready <= 1'b0;
            rsp_valid      <= 1'b1;
            rsp_write      <= 1'b0;
            rsp_rdata      <= mem_axi_rdata;
            rsp_resp       <= mem_axi_rresp;
            rd_count       <= rd_count + 32'd1;
            state          <= RSP;
          end
        end

        RSP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  cl_mem_axi_wdog #(
    .TIMEOUT(TIMEOUT)
  ) u_wdog (
    .clk        (clk),
    .rstn       (rstn),
    .clr        (cmd_fire),
    .en         (wdog_en),
    .err_timeout(err_timeout)
  );

endmodule

// File: tb/tb_cl_mem_axi_master.sv
// Bench for cl_mem_axi_master: a behavioural memory responder with delay knobs,
// a vector table, hand-built corner sequences and a randomized model check.
module tb_cl_mem_axi_master;
  import cl_mem_axi_pkg::*;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
  logic [63:0] cmd_addr = '0, cmd_wdata = '0;
  logic [7:0]  cmd_wstrb = '0;
  logic        rsp_valid, rsp_ready = 1'b1, rsp_write;
  logic [63:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic        awvalid, awready, wvalid, wready, bvalid, bready, arvalid, arready, rvalid, rready;
  logic [63:0] awaddr, wdata, araddr, rdata;
  logic [7:0]  wstrb;
  logic [1:0]  bresp, rresp;
  logic [31:0] wr_count, rd_count;
  logic        err_timeout;

  always #5 clk = ~clk;

  cl_mem_axi_master #(.TIMEOUT(8)) dut (
    .clk(clk), .rstn(rstn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .mem_axi_awvalid(awvalid), .mem_axi_awready(awready), .mem_axi_awaddr(awaddr),
    .mem_axi_wvalid(wvalid), .mem_axi_wready(wready), .mem_axi_wdata(wdata), .mem_axi_wstrb(wstrb),
    .mem_axi_bvalid(bvalid), .mem_axi_bready(bready), .mem_axi_bresp(bresp),
    .mem_axi_arvalid(arvalid), .mem_axi_arready(arready), .mem_axi_araddr(araddr),
    .mem_axi_rvalid(rvalid), .mem_axi_rready(rready), .mem_axi_rresp(rresp), .mem_axi_rdata(rdata),
    .wr_count(wr_count), .rd_count(rd_count), .err_timeout(err_timeout)
  );

  // Responder knobs: ready delays in cycles, blocking switches and error injection.
  int   aw_delay = 0, w_delay = 2, ar_delay = 0;
  logic ar_block = 1'b0, b_block = 1'b0, b_after_w = 1'b0, err_cfg = 1'b0, mem_init = 1'b0;
  int   aw_cnt = 0, w_cnt = 0, ar_cnt = 0;
  logic got_aw = 1'b0, got_w = 1'b0;
  logic [63:0] aw_q = '0, wd_q = '0;
  logic [7:0]  ws_q = '0;
  logic [63:0] mem [0:8191];
  int   rsp_hs = 0;

  function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] d, input logic [7:0] s);
    logic [63:0] r;
    r = old;
    for (int b = 0; b < 8; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  assign awready = (aw_cnt >= aw_delay);
  assign wready  = (w_cnt >= w_delay);
  assign arready = !ar_block && (ar_cnt >= ar_delay);

  // Simulation memory responder; B may optionally be offered as soon as W lands.
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 8192; i++) mem[i] <= '0;
      mem[13'h200] <= 64'hDEADBEEF_CAFEF00D;
    end
    if (!rstn) begin
      aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0;
      got_aw <= 1'b0; got_w <= 1'b0;
      bvalid <= 1'b0; rvalid <= 1'b0; bresp <= '0; rresp <= '0; rdata <= '0;
    end else begin
      if (awvalid && !awready) aw_cnt <= aw_cnt + 1; else if (!awvalid) aw_cnt <= 0;
      if (wvalid && !wready) w_cnt <= w_cnt + 1; else if (!wvalid) w_cnt <= 0;
      if (arvalid && !arready) ar_cnt <= ar_cnt + 1; else if (!arvalid) ar_cnt <= 0;
      if (awvalid && awready) begin got_aw <= 1'b1; aw_q <= awaddr; end
      if (wvalid && wready) begin got_w <= 1'b1; wd_q <= wdata; ws_q <= wstrb; end
      if (bvalid && bready) begin
        bvalid <= 1'b0; got_aw <= 1'b0; got_w <= 1'b0;
        mem[aw_q[15:3]] <= merge(mem[aw_q[15:3]], wd_q, ws_q);
      end else if (!bvalid && !b_block && (got_w || (wvalid && wready)) &&
                   (b_after_w || got_aw || (awvalid && awready))) begin
        bvalid <= 1'b1;
        bresp  <= err_cfg ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
      end
      if (arvalid && arready) begin
        rvalid <= 1'b1;
        rdata  <= mem[araddr[15:3]];
        rresp  <= err_cfg ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
      end else if (rvalid && rready) begin
        rvalid <= 1'b0;
      end
    end
  end

  always @(posedge clk) if (rstn && rsp_valid && rsp_ready) rsp_hs <= rsp_hs + 1;

  int total = 0, bad = 0;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues one command, waits for its response and accepts it; lat is cycles from accept to rsp_valid.
  task automatic applyStimulus(input logic w, input logic [63:0] a, input logic [63:0] d, input logic [7:0] s,
                               output logic [63:0] rd, output logic [1:0] rr, output logic rw,
                               output logic [63:0] req_addr, output int lat);
    int n;
    n = 0;
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s; rsp_ready = 1'b1;
    while (!cmd_ready && n < 50) begin tick(); n++; end
    checkOutput("cmd_accept", 64'(cmd_ready), 64'd1);
    tick();
    cmd_valid = 1'b0;
    req_addr = w ? awaddr : araddr;
    lat = 1;
    while (!rsp_valid && lat < 100) begin tick(); lat++; end
    checkOutput("rsp_wait", 64'(rsp_valid), 64'd1);
    rd = rsp_rdata; rr = rsp_resp; rw = rsp_write;
    tick();
  endtask

  typedef struct {
    logic        write;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [7:0]  wstrb;
    logic        err;
    logic [63:0] exp_addr;
    logic [63:0] exp_rdata;
    logic [1:0]  exp_resp;
    int          exp_lat;
  } vec_t;

  vec_t        vecs [6];
  logic [63:0] model_mem [8];
  logic [63:0] got_rdata, got_addr, s_rdata, exp_rdata;
  logic [1:0]  got_resp, s_resp;
  logic        got_write, s_write, stable, ready_low;
  int          got_lat, exp_wr, exp_rd, hs0, n;

  initial begin
    #2_000_000;
    $display("[TB] FAIL global_timeout: simulation did not finish");
    $fatal(1, "[TB] global timeout");
  end

  initial begin
    vecs[0] = '{1'b0, 64'h1003, 64'h0, 8'h00, 1'b0, 64'h1000, 64'hDEADBEEF_CAFEF00D, AXI_RESP_OKAY, 3};
    vecs[1] = '{1'b1, 64'h2000, 64'h11223344_55667788, 8'h0F, 1'b0, 64'h2000, 64'h0, AXI_RESP_OKAY, 5};
    vecs[2] = '{1'b0, 64'h2000, 64'h0, 8'h00, 1'b0, 64'h2000, 64'h00000000_55667788, AXI_RESP_OKAY, 3};
    vecs[3] = '{1'b1, 64'h1006, 64'hAAAAAAAA_AAAAAAAA, 8'hC3, 1'b1, 64'h1000, 64'h0, AXI_RESP_SLVERR, 5};
    vecs[4] = '{1'b0, 64'h1007, 64'h0, 8'h00, 1'b1, 64'h1000, 64'hAAAABEEF_CAFEAAAA, AXI_RESP_SLVERR, 3};
    vecs[5] = '{1'b0, 64'h3000, 64'h0, 8'h00, 1'b0, 64'h3000, 64'h0, AXI_RESP_OKAY, 3};
    for (int i = 0; i < 8; i++) model_mem[i] = '0;
    exp_wr = 0; exp_rd = 0;

    mem_init = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    mem_init = 1'b0;
    checkOutput("rst_cmd_ready", 64'(cmd_ready), 64'd1);
    checkOutput("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    checkOutput("rst_valids", {60'd0, awvalid, wvalid, arvalid, bready}, 64'd0);
    checkOutput("rst_rready", 64'(rready), 64'd0);
    checkOutput("rst_awaddr", awaddr, 64'd0);
    checkOutput("rst_wr_count", 64'(wr_count), 64'd0);
    checkOutput("rst_rd_count", 64'(rd_count), 64'd0);
    checkOutput("rst_err", 64'(err_timeout), 64'd0);
    rstn = 1'b1;
    tick();

    // Vector table with the default responder timing.
    for (int i = 0; i < 6; i++) begin
      err_cfg = vecs[i].err;
      applyStimulus(vecs[i].write, vecs[i].addr, vecs[i].wdata, vecs[i].wstrb,
                    got_rdata, got_resp, got_write, got_addr, got_lat);
      if (vecs[i].write) exp_wr++; else exp_rd++;
      checkOutput($sformatf("vec%0d_addr", i), got_addr, vecs[i].exp_addr);
      checkOutput($sformatf("vec%0d_rdata", i), got_rdata, vecs[i].exp_rdata);
      checkOutput($sformatf("vec%0d_resp", i), 64'(got_resp), 64'(vecs[i].exp_resp));
      checkOutput($sformatf("vec%0d_write", i), 64'(got_write), 64'(vecs[i].write));
      checkOutput($sformatf("vec%0d_lat", i), 64'(got_lat), 64'(vecs[i].exp_lat));
      checkOutput($sformatf("vec%0d_wr_count", i), 64'(wr_count), 64'(exp_wr));
      checkOutput($sformatf("vec%0d_rd_count", i), 64'(rd_count), 64'(exp_rd));
    end
    err_cfg = 1'b0;

    // W accepted first, AW two cycles later, B offered early by the responder.
    aw_delay = 2; w_delay = 0; b_after_w = 1'b1;
    hs0 = rsp_hs;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 64'h2008; cmd_wdata = 64'h01020304_05060708; cmd_wstrb = 8'hFF;
    tick();
    cmd_valid = 1'b0;
    checkOutput("awl_c1_valids", {62'd0, awvalid, wvalid}, 64'd3);
    tick();
    checkOutput("awl_c2_valids", {62'd0, awvalid, wvalid}, 64'd2);
    checkOutput("awl_c2_bready", 64'(bready), 64'd0);
    tick();
    checkOutput("awl_c3_valids", {62'd0, awvalid, wvalid}, 64'd2);
    checkOutput("awl_c3_bready", 64'(bready), 64'd0);
    tick();
    checkOutput("awl_c4_valids", {62'd0, awvalid, wvalid}, 64'd0);
    checkOutput("awl_c4_bready", 64'(bready), 64'd1);
    tick();
    checkOutput("awl_c5_rsp", {62'd0, rsp_valid, rsp_write}, 64'd3);
    repeat (6) tick();
    checkOutput("awl_one_rsp", 64'(rsp_hs - hs0), 64'd1);
    exp_wr++;
    aw_delay = 0; w_delay = 2; b_after_w = 1'b0;

    // Response stall with the next command already waiting.
    rsp_ready = 1'b0;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 64'h1000;
    tick();
    cmd_addr = 64'h2000;
    n = 0;
    while (!rsp_valid && n < 50) begin tick(); n++; end
    checkOutput("stl_rsp_valid", 64'(rsp_valid), 64'd1);
    s_rdata = rsp_rdata; s_resp = rsp_resp; s_write = rsp_write;
    stable = 1'b1; ready_low = 1'b1;
    repeat (10) begin
      tick();
      if (cmd_ready) ready_low = 1'b0;
      if (!rsp_valid || rsp_rdata !== s_rdata || rsp_resp !== s_resp || rsp_write !== s_write) stable = 1'b0;
    end
    checkOutput("stl_cmd_ready_low", 64'(ready_low), 64'd1);
    checkOutput("stl_fields_stable", 64'(stable), 64'd1);
    checkOutput("stl_rdata", s_rdata, 64'hAAAABEEF_CAFEAAAA);
    rsp_ready = 1'b1;
    tick();
    checkOutput("stl_ready_after", 64'(cmd_ready), 64'd1);
    tick();
    cmd_valid = 1'b0;
    checkOutput("stl_second_ar", {arvalid, araddr[62:0]}, {1'b1, 63'h2000});
    n = 0;
    while (!rsp_valid && n < 50) begin tick(); n++; end
    checkOutput("stl_second_rdata", rsp_rdata, 64'h00000000_55667788);
    tick();
    exp_rd += 2;
    checkOutput("stl_rd_count", 64'(rd_count), 64'(exp_rd));

    // Randomized traffic checked against a plain memory model.
    for (int i = 0; i < 40; i++) begin
      int k;
      logic w, e;
      logic [63:0] a, d;
      logic [7:0] s;
      w = 1'($urandom_range(0, 1));
      k = $urandom_range(0, 7);
      a = 64'h4000 + 64'(k * 8) + 64'($urandom_range(0, 7));
      d = {$urandom, $urandom};
      s = 8'($urandom_range(0, 255));
      e = ($urandom_range(0, 3) == 0);
      aw_delay = $urandom_range(0, 3); w_delay = $urandom_range(0, 3); ar_delay = $urandom_range(0, 3);
      err_cfg = e;
      if (w) begin
        model_mem[k] = merge(model_mem[k], d, s);
        exp_rdata = '0;
        exp_wr++;
      end else begin
        exp_rdata = model_mem[k];
        exp_rd++;
      end
      applyStimulus(w, a, d, s, got_rdata, got_resp, got_write, got_addr, got_lat);
      checkOutput($sformatf("rnd%0d_rdata", i), got_rdata, exp_rdata);
      checkOutput($sformatf("rnd%0d_resp", i), 64'(got_resp), e ? 64'(AXI_RESP_SLVERR) : 64'(AXI_RESP_OKAY));
      checkOutput($sformatf("rnd%0d_write", i), 64'(got_write), 64'(w));
      checkOutput($sformatf("rnd%0d_addr", i), got_addr, {a[63:3], 3'b000});
    end
    checkOutput("rnd_wr_count", 64'(wr_count), 64'(exp_wr));
    checkOutput("rnd_rd_count", 64'(rd_count), 64'(exp_rd));
    aw_delay = 0; w_delay = 2; ar_delay = 0; err_cfg = 1'b0;

    // Watchdog: AR held off well past the limit, then released.
    ar_block = 1'b1;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 64'h1000; rsp_ready = 1'b1;
    tick();
    cmd_valid = 1'b0;
    repeat (7) tick();
    checkOutput("wd_not_yet", 64'(err_timeout), 64'd0);
    repeat (2) tick();
    checkOutput("wd_set", 64'(err_timeout), 64'd1);
    repeat (10) tick();
    checkOutput("wd_still_waiting", 64'(arvalid), 64'd1);
    ar_block = 1'b0;
    n = 0;
    while (!rsp_valid && n < 50) begin tick(); n++; end
    checkOutput("wd_rdata", rsp_rdata, 64'hAAAABEEF_CAFEAAAA);
    tick();
    checkOutput("wd_sticky", 64'(err_timeout), 64'd1);

    // Reset while waiting for B.
    b_block = 1'b1;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 64'h2010; cmd_wdata = 64'h5; cmd_wstrb = 8'hFF;
    tick();
    cmd_valid = 1'b0;
    n = 0;
    while (!bready && n < 20) begin tick(); n++; end
    checkOutput("rst_mid_in_wr_resp", 64'(bready), 64'd1);
    rstn = 1'b0;
    #1;
    checkOutput("rst_mid_cmd_ready", 64'(cmd_ready), 64'd1);
    checkOutput("rst_mid_bready", 64'(bready), 64'd0);
    checkOutput("rst_mid_awaddr", awaddr, 64'd0);
    checkOutput("rst_mid_counts", {wr_count, rd_count}, 64'd0);
    checkOutput("rst_mid_err", 64'(err_timeout), 64'd0);
    @(posedge clk);
    #1;
    rstn = 1'b1; b_block = 1'b0;
    tick();
    applyStimulus(1'b0, 64'h1003, 64'h0, 8'h00, got_rdata, got_resp, got_write, got_addr, got_lat);
    checkOutput("post_rst_rdata", got_rdata, 64'hAAAABEEF_CAFEAAAA);
    checkOutput("post_rst_resp", 64'(got_resp), 64'(AXI_RESP_OKAY));
    checkOutput("post_rst_counts", {wr_count, rd_count}, {32'd0, 32'd1});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cl_mem_axi_master.md
# cl_mem_axi_master

Single-outstanding command-driven initiator for the simplified 64-bit single-beat memory AXI interface (`mem_axi_*`: AW/W/B/AR/R, no IDs, no bursts). It converts a valid/ready command port into one write (AW+W then B) or one read (AR then R) transaction. It returns the result on a valid/ready response port. It is the master side of the simulation memory responder and is used by CL test logic to drive memory traffic through RTL instead of backdoor calls.

## Interface
Parameters:
- `TIMEOUT`, 1024 — watchdog limit in cycles per transaction; 0 disables the watchdog.

Ports:
- `clk`  in  1  clock; single clock domain.
- `rstn`  in  1  reset; asynchronous, active-low.
- `cmd_valid` / `cmd_ready`  in / out  1 / 1  command handshake.
- `cmd_write`  in  1  1 = write, 0 = read.
- `cmd_addr`  in  64  byte address.
- `cmd_wdata`  in  64  write data; ignored for reads.
- `cmd_wstrb`  in  8  byte enables; ignored for reads.
- `rsp_valid` / `rsp_ready`  out / in  1 / 1  response handshake.
- `rsp_write`  out  1  echoes `cmd_write`.
- `rsp_rdata`  out  64  read data; 0 for writes.
- `rsp_resp`  out  2  `bresp` or `rresp`.
- `mem_axi_awvalid` out 1, `mem_axi_awready` in 1, `mem_axi_awaddr` out 64.
- `mem_axi_wvalid` out 1, `mem_axi_wready` in 1, `mem_axi_wdata` out 64, `mem_axi_wstrb` out 8.
- `mem_axi_bvalid` in 1, `mem_axi_bready` out 1, `mem_axi_bresp` in 2.
- `mem_axi_arvalid` out 1, `mem_axi_arready` in 1, `mem_axi_araddr` out 64.
- `mem_axi_rvalid` in 1, `mem_axi_rready` out 1, `mem_axi_rresp` in 2, `mem_axi_rdata` in 64.
- `wr_count` / `rd_count`  out  32 / 32  completed transactions; wrap modulo 2^32.
- `err_timeout`  out  1  sticky watchdog flag.

## Operation
- FSM states and transitions:
  - IDLE: on cmd handshake, go to WR_REQ if `cmd_write`, else RD_ADDR.
  - WR_REQ: go to WR_RESP once both the AW and W handshakes have occurred.
  - WR_RESP: go to RSP on B handshake.
  - RD_ADDR: go to RD_DATA on AR handshake.
  - RD_DATA: go to RSP on R handshake.
  - RSP: go to IDLE on `rsp_valid & rsp_ready`.
- `cmd_ready` = (state == IDLE); combinational from the state register.
- Address handling: on command accept, register `{cmd_addr[63:3],3'b0}` onto `awaddr`/`araddr`; bits [2:0] are always 0. Register data and strobe onto `wdata`/`wstrb`.
- WR_REQ:
  - `awvalid` and `wvalid` rise together on WR_REQ entry.
  - Each drops independently after its own handshake and never reasserts for the same transaction.
  - AW and W handshakes may occur in either order or in the same cycle.
  - W is allowed to complete before AW.
- `bready` = 1 only in WR_RESP; `rready` = 1 only in RD_DATA.
- A `bvalid` arriving while still in WR_REQ is held off until WR_RESP.
- R handshake: capture `rdata` and `rresp`.
- B handshake: capture `bresp`; `rsp_rdata` = 0.
- `rsp_valid` is registered, high throughout RSP. Response fields stay stable until accepted.
- Counters:
  - `wr_count` increments on B handshake; `rd_count` increments on R handshake.
- Watchdog:
  - A 16-bit cycle counter clears on command accept and counts in WR_REQ, WR_RESP, RD_ADDR and RD_DATA.
  - When the counter equals `TIMEOUT` (nonzero), `err_timeout` sets. It clears only on reset.
  - The transaction is not aborted; the FSM keeps waiting.
  - The counter saturates and does not wrap.

## Timing
- Reset values: all outputs 0, except `cmd_ready` = 1 (IDLE). Internal registers 0, state IDLE.
- Reset mid-transaction clears state asynchronously; the in-flight transaction is abandoned and no response is produced.
- Cycle-level latency against the simulation memory responder, with cmd accepted in cycle 0:
  - Read: `arvalid` cycle 1, R handshake cycle 2, `rsp_valid` cycle 3.
  - Write: `awvalid`/`wvalid` cycle 1, AW handshake cycle 1, W handshake cycle 3, B handshake cycle 4, `rsp_valid` cycle 5.
- Back-to-back: the next command is accepted in the cycle after the response handshake. No overlap of transactions.
- `rsp_ready` held low stalls the block in RSP indefinitely. No commands are accepted during the stall, and the watchdog does not count.

## Structure
- Package `cl_mem_axi_pkg`:
  - state enum `mem_axi_mst_state_e` (IDLE, WR_REQ, WR_RESP, RD_ADDR, RD_DATA, RSP).
  - response constants `AXI_RESP_OKAY=2'b00`, `AXI_RESP_SLVERR=2'b10`.
  - watchdog width constant `MEM_AXI_WDOG_W=16`.
- One sub-module, `cl_mem_axi_wdog`: clear/enable/saturate counter plus sticky flag, parameterised by `TIMEOUT`.
- Everything else flat in `cl_mem_axi_master`.

## Test plan
- Read at `cmd_addr=0x1003` against memory holding `0xDEADBEEF_CAFEF00D` at 0x1000:
  - `araddr=0x1000`.
  - `rsp_valid` 3 cycles after accept with `rsp_rdata=0xDEADBEEF_CAFEF00D`, `rsp_resp=0`, `rd_count=1`.
- Write `0x11223344_55667788`, `wstrb=0x0F` to 0x2000 over prior contents of 0:
  - response after 5 cycles with `rsp_resp=0`.
  - readback returns `0x00000000_55667788`; `wr_count=1`.
- Responder model asserts `wready` before `awready`, then `awready` 2 cycles later:
  - each valid drops after its own handshake.
  - `bready` is asserted only after both handshakes.
  - exactly one response is produced.
- `rsp_ready=0` for 10 cycles with `cmd_valid=1` held:
  - `cmd_ready` stays 0.
  - response fields stay stable.
  - second command is accepted the cycle after `rsp_ready=1`.
- `TIMEOUT=8`, `arready` held 0:
  - `err_timeout` rises after 8 cycles in RD_ADDR.
  - releasing `arready` completes the read normally; the flag stays set.
- Deassert `rstn` in WR_RESP:
  - all outputs return to reset values immediately.
  - after release, a new read completes normally.
